single_p_decoder: RTL and testbench

Sequential inverse of the 4-input single-priority encoder: it accepts a 2-bit priority code (plus an all-zero flag) through a valid/ready handshake and drives the matching one-hot line. The line is held for a programmable number of cycles, followed by an optional idle gap. The block sits downstream of the encoder and turns grant indices back into per-line strobes for the four requesters. It has one input buffer entry, so a new code can be accepted while the current one is being driven.

---
 rtl/single_p_decoder.sv | 164 ++++++++++++++++
 tb/tb_single_p_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_p_decoder.sv
// single_p_decoder
//   Turns 2-bit priority-encoder grant codes back into one-hot strobes for the
//   four requesters. Each accepted word is driven for HOLD cycles, then GAP
//   forced idle cycles. One input buffer entry lets the next word be accepted
//   while the current one is on the outputs.
//
//   Parameters
//     HOLD  cycles each word is driven (1..255)
//     GAP   idle cycles after each word (0..255)
//
//   Ports
//     clk         clock, rising edge
//     rst_n       synchronous active-low reset
//     in_valid    input word present
//     in_ready    buffer empty, word will be accepted
//     in_code     priority code, 00 = line 3 ... 11 = line 0
//     in_zero     encoder saw no request; code ignored, outputs stay 0000
//     out_valid   a word is being driven
//     out_onehot  decoded line (0000 while out_valid is low)
//     busy        FSM not idle or buffer holding a word
//     dec_count   buffer pop counter, only when SPD_STATS_EN is defined
//
//   Optional feature macro: SPD_STATS_EN
//
//   state | meaning
//   IDLE  | nothing driven, waiting for a buffered word
//   DRIVE | out_valid high, cnt counts down the HOLD window
//   GAP   | forced idle, cnt counts down the GAP window
module single_p_decoder #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_code,
  input  logic        in_zero,
  output logic        out_valid,
  output logic [3:0]  out_onehot,
  output logic        busy
`ifdef SPD_STATS_EN
  ,
  output logic [15:0] dec_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] onehot_q, onehot_d;
  logic       buf_valid_q, buf_valid_d;
  logic [1:0] buf_code_q, buf_code_d;
  logic       buf_zero_q, buf_zero_d;
  logic       push, pop;
  logic [3:0] buf_onehot;

  assign in_ready   = !buf_valid_q;
  assign push       = in_valid && !buf_valid_q;
  assign buf_onehot = buf_zero_q ? 4'b0000 : (4'b1000 >> buf_code_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (buf_valid_q) pop = 1'b1;
      end
      S_DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP > 0) begin
          state_d     = S_GAP;
          cnt_d       = GAP_LOAD;
          out_valid_d = 1'b0;
          onehot_d    = 4'b0000;
        end else if (buf_valid_q) begin
          pop = 1'b1;
        end else begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          onehot_d    = 4'b0000;
        end
      end
      S_GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (buf_valid_q) begin
          pop = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every pop starts a fresh HOLD window regardless of the state it came from.
    if (pop) begin
      state_d     = S_DRIVE;
      cnt_d       = HOLD_LOAD;
      out_valid_d = 1'b1;
      onehot_d    = buf_onehot;
    end

    // Push only happens into an empty buffer and pop only from a full one,
    // so the two never act on the same entry in one cycle.
    buf_valid_d = buf_valid_q;
    buf_code_d  = buf_code_q;
    buf_zero_d  = buf_zero_q;
    if (pop) buf_valid_d = 1'b0;
    if (push) begin
      buf_valid_d = 1'b1;
      buf_code_d  = in_code;
      buf_zero_d  = in_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      onehot_q    <= 4'b0000;
      buf_valid_q <= 1'b0;
      buf_code_q  <= 2'b00;
      buf_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      buf_valid_q <= buf_valid_d;
      buf_code_q  <= buf_code_d;
      buf_zero_q  <= buf_zero_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = onehot_q;
  assign busy       = (state_q != S_IDLE) || buf_valid_q;

`ifdef SPD_STATS_EN
  logic [15:0] dec_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_count_q <= 16'd0;
    end else if (pop) begin
      dec_count_q <= dec_count_q + 16'd1;
    end
  end

  assign dec_count = dec_count_q;
`endif

endmodule

// File: tb/tb_single_p_decoder.sv
// Bench for single_p_decoder: three instances (HOLD/GAP = 4/1, 4/0, 1/2) are
// checked every cycle against a timestamp model: each accepted word gets an
// acceptance edge and a start edge, and all outputs follow from those.
module tb_single_p_decoder;

  function automatic int hold_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_valid = 3'b000;
  logic [2:0] in_ready;
  logic [2:0] in_zero = 3'b000;
  logic [2:0] out_valid;
  logic [2:0] busy;
  logic [1:0] in_code [3];
  logic [3:0] out_onehot [3];
`ifdef SPD_STATS_EN
  logic [15:0] dec_count [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    single_p_decoder #(.HOLD(hold_of(g)), .GAP(gap_of(g))) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_code   (in_code[g]),
      .in_zero   (in_zero[g]),
      .out_valid (out_valid[g]),
      .out_onehot(out_onehot[g]),
      .busy      (busy[g])
`ifdef SPD_STATS_EN
      ,
      .dec_count (dec_count[g])
`endif
    );
  end

  int n_chk = 0;
  int n_err = 0;
  int t = 0;
  bit chk_en = 0;
  bit acc [3];
  int hi_cnt [3];
  int rise_cnt [3];
  bit prev_v [3];

  // model history: slot 1 newest word, slot 0 the one before it
  bit         hv [3][2];
  int         ha [3][2];
  int         hs [3][2];
  logic [3:0] ho [3][2];
  logic [3:0] dec_tab [4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic logic m_ready(input int i, input int tt);
    for (int j = 0; j < 2; j++)
      if (hv[i][j] && ha[i][j] <= tt && tt < hs[i][j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_valid(input int i, input int tt);
    for (int j = 0; j < 2; j++)
      if (hv[i][j] && hs[i][j] <= tt && tt < hs[i][j] + hold_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_onehot(input int i, input int tt);
    for (int j = 0; j < 2; j++)
      if (hv[i][j] && hs[i][j] <= tt && tt < hs[i][j] + hold_of(i)) return ho[i][j];
    return 4'b0000;
  endfunction

  function automatic logic m_busy(input int i, input int tt);
    for (int j = 0; j < 2; j++)
      if (hv[i][j] && ha[i][j] <= tt && tt < hs[i][j] + hold_of(i) + gap_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_push(input int i, input int a, input logic [1:0] c, input logic z);
    int s;
    s = a + 1;
    if (hv[i][1] && hs[i][1] + hold_of(i) + gap_of(i) > s) s = hs[i][1] + hold_of(i) + gap_of(i);
    hv[i][0] = hv[i][1];
    ha[i][0] = ha[i][1];
    hs[i][0] = hs[i][1];
    ho[i][0] = ho[i][1];
    hv[i][1] = 1'b1;
    ha[i][1] = a;
    hs[i][1] = s;
    ho[i][1] = z ? 4'b0000 : dec_tab[c];
  endtask

  task automatic step();
    for (int i = 0; i < 3; i++) acc[i] = rst_n && in_valid[i] && m_ready(i, t);
    @(posedge clk);
    t++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        hv[i][0] = 1'b0;
        hv[i][1] = 1'b0;
      end else if (acc[i]) begin
        m_push(i, t, in_code[i], in_zero[i]);
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i]) hi_cnt[i]++;
      if (out_valid[i] && !prev_v[i]) rise_cnt[i]++;
      prev_v[i] = out_valid[i];
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_mon();
    for (int i = 0; i < 3; i++) begin
      hi_cnt[i] = 0;
      rise_cnt[i] = 0;
    end
  endtask

  task automatic push(input int i, input logic [1:0] c, input logic z);
    bit done;
    done = 1'b0;
    in_valid[i] = 1'b1;
    in_code[i] = c;
    in_zero[i] = z;
    for (int k = 0; k < 50 && !done; k++) begin
      step();
      done = acc[i];
    end
    in_valid[i] = 1'b0;
    chk("push_accept", 16'(done), 16'd1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[%0d]", i), 16'(in_ready[i]), 16'(m_ready(i, t)));
        chk($sformatf("out_valid[%0d]", i), 16'(out_valid[i]), 16'(m_valid(i, t)));
        chk($sformatf("out_onehot[%0d]", i), 16'(out_onehot[i]), 16'(m_onehot(i, t)));
        chk($sformatf("busy[%0d]", i), 16'(busy[i]), 16'(m_busy(i, t)));
      end
    end
  end

  initial begin
    dec_tab[0] = 4'b1000;
    dec_tab[1] = 4'b0100;
    dec_tab[2] = 4'b0010;
    dec_tab[3] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      in_code[i] = 2'b00;
      hv[i][0] = 1'b0;
      hv[i][1] = 1'b0;
      prev_v[i] = 1'b0;
    end
    clr_mon();

    // reset
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", 16'(in_ready[0]), 16'd1);
    chk("rst_busy", 16'(busy[0]), 16'd0);

    // code 00: four cycles of 1000 starting one cycle after acceptance
    clr_mon();
    push(0, 2'b00, 1'b0);
    step();
    chk("first_onehot", 16'(out_onehot[0]), 16'h8);
    chk("first_valid", 16'(out_valid[0]), 16'd1);
    steps(7);
    chk("first_hold", 16'(hi_cnt[0]), 16'd4);
    chk("first_busy_done", 16'(busy[0]), 16'd0);

    // codes 01, 10, 11 back to back: three separate 4-cycle strobes
    clr_mon();
    push(0, 2'b01, 1'b0);
    push(0, 2'b10, 1'b0);
    push(0, 2'b11, 1'b0);
    steps(20);
    chk("seq_hi_cycles", 16'(hi_cnt[0]), 16'd12);
    chk("seq_rises", 16'(rise_cnt[0]), 16'd3);

    // zero word: valid with no line
    push(0, 2'b10, 1'b1);
    step();
    chk("zero_valid", 16'(out_valid[0]), 16'd1);
    chk("zero_onehot", 16'(out_onehot[0]), 16'h0);
    steps(8);

    // GAP=0 instance: two words with no bubble
    clr_mon();
    push(1, 2'b01, 1'b0);
    push(1, 2'b11, 1'b0);
    chk("gap0_full_ready", 16'(in_ready[1]), 16'd0);
    steps(12);
    chk("gap0_hi_cycles", 16'(hi_cnt[1]), 16'd8);
    chk("gap0_rises", 16'(rise_cnt[1]), 16'd1);

    // reset in the second DRIVE cycle with a word buffered
    push(0, 2'b01, 1'b0);
    in_valid[0] = 1'b1;
    in_code[0] = 2'b11;
    in_zero[0] = 1'b0;
    steps(2);
    in_valid[0] = 1'b0;
    chk("pre_rst_ready", 16'(in_ready[0]), 16'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_valid", 16'(out_valid[0]), 16'd0);
    chk("abort_onehot", 16'(out_onehot[0]), 16'h0);
    chk("abort_busy", 16'(busy[0]), 16'd0);
    chk("abort_ready", 16'(in_ready[0]), 16'd1);
    clr_mon();
    steps(15);
    chk("abort_no_drive", 16'(hi_cnt[0]), 16'd0);

    // random traffic on all three instances, occasional reset
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_code[i]  = 2'($urandom_range(0, 3));
        in_zero[i]  = ($urandom_range(0, 7) == 0);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    in_valid = 3'b000;
    rst_n = 1'b1;
    steps(12);

`ifdef SPD_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push(0, 2'b00, 1'b0);
    push(0, 2'b01, 1'b1);
    push(0, 2'b11, 1'b0);
    steps(12);
    chk("dec_count_3", dec_count[0], 16'd3);
    force g_dut[0].dut.dec_count_q = 16'hFFFF;
    step();
    release g_dut[0].dut.dec_count_q;
    push(0, 2'b10, 1'b0);
    steps(8);
    chk("dec_count_wrap", dec_count[0], 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
